// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC datapath.
//   DEF_WIDTH / DEF_STAGES : default CORDIC data width and pipeline latency
//   CORDIC_GAIN_INV        : round(0.6072529 * 2^15), inverse CORDIC gain
//   GAIN_FRAC_BITS         : fractional bits of CORDIC_GAIN_INV
//   COEF_W                 : signed width needed to hold CORDIC_GAIN_INV
package cordic_pkg;
  localparam int DEF_WIDTH       = 16;
  localparam int DEF_STAGES      = 16;
  localparam int CORDIC_GAIN_INV = 19898;
  localparam int GAIN_FRAC_BITS  = 15;
  localparam int COEF_W          = GAIN_FRAC_BITS + 1;
endpackage

// File: rtl/cordic_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is always visible
// on rdata; a push into a full FIFO is accepted only if a pop happens in the
// same cycle.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (pointers/level only)
//   push, wdata    : write request and data
//   pop            : read request (ignored when empty)
//   rdata          : oldest entry
//   empty, full    : occupancy flags
//   level          : occupancy 0..DEPTH
module cordic_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty,
  output logic              full,
  output logic [LW-1:0]     level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/cordic_out_stage.sv
// Output stage of the CORDIC: tracks sample validity through the CORDIC
// latency, applies the inverse CORDIC gain with rounding and saturation, and
// buffers the results in a FWFT FIFO with a sticky drop flag.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid             : sample presented to the CORDIC this cycle
//   cordic_x, cordic_y   : CORDIC results (WIDTH+1 bits, signed)
//   out_valid, out_ready : output handshake (out_valid = FIFO non-empty)
//   out_x, out_y         : gain-compensated head of FIFO (0 while empty)
//   level                : FIFO occupancy
//   overflow, ovf_clr    : sticky drop flag and its synchronous clear
module cordic_out_stage
  import cordic_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES,
  parameter int DEPTH  = 8,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [WIDTH:0]   cordic_x,
  input  logic signed [WIDTH:0]   cordic_y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_x,
  output logic signed [WIDTH-1:0] out_y,
  output logic [LW-1:0]           level,
  output logic                    overflow,
  input  logic                    ovf_clr
);

  localparam int PROD_W = WIDTH + 1 + COEF_W;
  localparam logic signed [PROD_W-1:0] GAIN    = PROD_W'(CORDIC_GAIN_INV);
  localparam logic signed [PROD_W-1:0] RND     = PROD_W'(2 ** (GAIN_FRAC_BITS - 1));
  localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(2 ** (WIDTH - 1)));

  // Round half up, then drop the gain's fractional bits (arithmetic shift).
  function automatic logic signed [PROD_W-1:0] round_shift(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] t;
    t = p + RND;
    return t >>> GAIN_FRAC_BITS;
  endfunction

  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [PROD_W-1:0] v);
    if (v > SAT_MAX) return WIDTH'(SAT_MAX);
    if (v < SAT_MIN) return WIDTH'(SAT_MIN);
    return WIDTH'(v);
  endfunction

  logic [STAGES-1:0]          vld_sr;
  logic                       vld_p0;
  logic signed [PROD_W-1:0]   x_ext_p0;
  logic signed [PROD_W-1:0]   y_ext_p0;
  logic                       vld_p1;
  logic signed [PROD_W-1:0]   prod_x_p1;
  logic signed [PROD_W-1:0]   prod_y_p1;
  logic signed [WIDTH-1:0]    sat_x_p1;
  logic signed [WIDTH-1:0]    sat_y_p1;
  logic [2*WIDTH-1:0]         head;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       pop;
  logic                       drop;

  // Stage p0: in_valid delayed by the CORDIC latency marks the cycle whose
  // cordic_x/cordic_y belong to a real sample. The concatenation-and-truncate
  // form shifts in in_valid for any STAGES >= 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_sr <= '0;
    else        vld_sr <= STAGES'({vld_sr, in_valid});
  end

  assign vld_p0   = vld_sr[STAGES-1];
  assign x_ext_p0 = PROD_W'(cordic_x);
  assign y_ext_p0 = PROD_W'(cordic_y);

  // Stage p1: registered gain products with their valid bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (vld_p0) begin
      prod_x_p1 <= x_ext_p0 * GAIN;
      prod_y_p1 <= y_ext_p0 * GAIN;
    end
  end

  assign sat_x_p1 = saturate(round_shift(prod_x_p1));
  assign sat_y_p1 = saturate(round_shift(prod_y_p1));

  // Stage p2: FIFO write at the end of the p1 cycle; head is visible next cycle.
  assign pop  = out_valid && out_ready;
  assign drop = vld_p1 && fifo_full && !pop;

  cordic_sync_fifo #(
    .DATA_W (2 * WIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_p1),
    .wdata ({sat_x_p1, sat_y_p1}),
    .pop   (pop),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );

  assign out_valid = !fifo_empty;
  // Gate the head so unwritten storage never leaks out while empty or in reset.
  assign out_x = out_valid ? head[2*WIDTH-1:WIDTH] : '0;
  assign out_y = out_valid ? head[WIDTH-1:0]       : '0;

  // A drop in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_cordic_out_stage.sv
// Bench for cordic_out_stage: directed and random sequences checked each
// cycle against a queue-based model of the output stage.
module tb_cordic_out_stage;
  localparam int WIDTH  = 16;
  localparam int STAGES = 16;
  localparam int DEPTH  = 8;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int XW     = WIDTH + 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    out_ready = 1'b0;
  logic                    ovf_clr = 1'b0;
  logic signed [WIDTH:0]   cordic_x = '0;
  logic signed [WIDTH:0]   cordic_y = '0;
  logic                    out_valid;
  logic signed [WIDTH-1:0] out_x;
  logic signed [WIDTH-1:0] out_y;
  logic [LW-1:0]           level;
  logic                    overflow;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // CORDIC result schedule (cycle-indexed ring), pending writes, model FIFO.
  bit sch_v [64];
  int sch_x [64];
  int sch_y [64];
  int wq_t[$];
  int wq_x[$];
  int wq_y[$];
  int mq_x[$];
  int mq_y[$];
  bit exp_ovf = 1'b0;

  int e2e_cx [4] = '{16468, 0, -16468, 0};
  int e2e_cy [4] = '{0, 16468, 0, -16468};
  int e2e_tx [4] = '{10000, 0, -10000, 0};
  int e2e_ty [4] = '{0, 10000, 0, -10000};

  cordic_out_stage #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .cordic_x  (cordic_x),
    .cordic_y  (cordic_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .level     (level),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  // value * K / 2^15, rounded half up, clamped to the output range
  function automatic int exp_scale(input int v);
    longint p;
    longint hi;
    hi = (longint'(1) <<< (WIDTH - 1)) - 1;
    p = (longint'(v) * 19898 + 16384) >>> 15;
    if (p > hi) p = hi;
    if (p < -hi - 1) p = -hi - 1;
    return int'(p);
  endfunction

  function automatic int rnd_val();
    if ($urandom_range(0, 7) == 0)
      return ($urandom_range(0, 1) == 1) ? 65535 : -65536;
    return int'($urandom_range(0, 131071)) - 65536;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    bit ne;
    ne = (mq_x.size() > 0);
    chk("out_valid", out_valid, ne);
    chk("level", level, mq_x.size());
    chk("overflow", overflow, exp_ovf);
    chk("out_x", out_x, ne ? mq_x[0] : 0);
    chk("out_y", out_y, ne ? mq_y[0] : 0);
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic tick(input bit iv, input int xv, input int yv, input bit rdy, input bit clr);
    int  slot;
    bit  popd;
    bit  dropd;
    in_valid  = iv;
    out_ready = rdy;
    ovf_clr   = clr;
    if (iv) begin
      slot = (cyc + STAGES) % 64;
      sch_v[slot] = 1'b1;
      sch_x[slot] = xv;
      sch_y[slot] = yv;
    end
    slot = cyc % 64;
    if (sch_v[slot]) begin
      cordic_x = XW'(sch_x[slot]);
      cordic_y = XW'(sch_y[slot]);
      wq_t.push_back(cyc + 1);
      wq_x.push_back(exp_scale(sch_x[slot]));
      wq_y.push_back(exp_scale(sch_y[slot]));
      sch_v[slot] = 1'b0;
    end else begin
      cordic_x = XW'(rnd_val());
      cordic_y = XW'(rnd_val());
    end
    popd  = (mq_x.size() > 0) && rdy;
    dropd = 1'b0;
    if (popd) begin
      void'(mq_x.pop_front());
      void'(mq_y.pop_front());
    end
    if (wq_t.size() > 0 && wq_t[0] == cyc) begin
      if (mq_x.size() < DEPTH) begin
        mq_x.push_back(wq_x[0]);
        mq_y.push_back(wq_y[0]);
      end else begin
        dropd = 1'b1;
      end
      void'(wq_t.pop_front());
      void'(wq_x.pop_front());
      void'(wq_y.pop_front());
    end
    if (dropd)    exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    ovf_clr   = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    for (int i = 0; i < 64; i++) sch_v[i] = 1'b0;
    wq_t.delete(); wq_x.delete(); wq_y.delete();
    mq_x.delete(); mq_y.delete();
    exp_ovf = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    do_reset();
    repeat (2) tick(0, 0, 0, 0, 0);

    // Latency: pulse in cycle 0, result at cycle 16, head visible in cycle 18.
    tick(1, 16468, 0, 0, 0);
    repeat (16) tick(0, 0, 0, 0, 0);
    chk("lat_early_valid", out_valid, 0);
    tick(0, 0, 0, 0, 0);
    chk("lat_valid", out_valid, 1);
    chk("lat_x", out_x, 10000);
    chk("lat_y", out_y, 0);
    tick(0, 0, 0, 1, 0);

    // Saturation at both rails.
    tick(1, 65535, -65536, 0, 0);
    repeat (STAGES + 1) tick(0, 0, 0, 0, 0);
    chk("sat_x", out_x, 32767);
    chk("sat_y", out_y, -32768);
    tick(0, 0, 0, 1, 0);

    // Overflow: 10 samples with no reader, then clear and drain in order.
    for (int i = 0; i < 10; i++) tick(1, rnd_val(), rnd_val(), 0, 0);
    repeat (STAGES + 4) tick(0, 0, 0, 0, 0);
    chk("ovf_level", level, DEPTH);
    chk("ovf_flag", overflow, 1);
    tick(0, 0, 0, 0, 1);
    chk("ovf_cleared", overflow, 0);
    repeat (DEPTH + 2) tick(0, 0, 0, 1, 0);

    // Throughput: fill, then read one per clock against continuous input.
    for (int i = 0; i < 40; i++) begin
      tick(1, rnd_val(), rnd_val(), (i >= STAGES + 9), 0);
      if (i >= STAGES + 9) begin
        chk("thru_level", level, DEPTH);
        chk("thru_ovf", overflow, 0);
      end
    end
    repeat (STAGES + DEPTH + 4) tick(0, 0, 0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      tick(($urandom_range(0, 3) != 0), rnd_val(), rnd_val(),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0));
    repeat (STAGES + DEPTH + 4) tick(0, 0, 0, 1, 1);

    // Reset with a sample in flight: nothing may come out afterwards.
    tick(1, 1234, -4321, 1, 0);
    repeat (9) tick(0, 0, 0, 1, 0);
    do_reset();
    repeat (STAGES + 10) tick(0, 0, 0, 1, 0);
    chk("flight_level", level, 0);
    chk("flight_valid", out_valid, 0);

    // End to end with idealised CORDIC outputs for 0/90/180/270 degrees.
    for (int k = 0; k < 4; k++) tick(1, e2e_cx[k], e2e_cy[k], 0, 0);
    repeat (STAGES + 2) tick(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      int dx;
      int dy;
      dx = int'(out_x) - e2e_tx[k];
      dy = int'(out_y) - e2e_ty[k];
      if (dx < 0) dx = -dx;
      if (dy < 0) dy = -dy;
      chk("e2e_x_tol", (dx <= 3), 1);
      chk("e2e_y_tol", (dy <= 3), 1);
      tick(0, 0, 0, 1, 0);
    end
    repeat (4) tick(0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cordic_out_stage.md
CORDIC_OUT_STAGE -- requirements
Module: cordic_out_stage

Interface
REQ-001 Parameter WIDTH, default 16: CORDIC data width; the CORDIC results are WIDTH+1 bits and the outputs are WIDTH bits.
REQ-002 Parameter STAGES, default 16: CORDIC pipeline latency in clocks; it equals WIDTH for the current CORDIC.
REQ-003 Parameter DEPTH, default 8: output FIFO depth; it is a power of two and at least 2.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert and active-low.
REQ-006 in_valid  in  1  high in the same cycle that angle, Xin and Yin are presented to the CORDIC.
REQ-007 cordic_x  in  WIDTH+1 signed  CORDIC Xout.
REQ-008 cordic_y  in  WIDTH+1 signed  CORDIC Yout.
REQ-009 out_valid  out  1  FIFO non-empty.
REQ-010 out_ready  in  1  downstream accept.
REQ-011 out_x  out  WIDTH signed  gain-compensated X at FIFO head.
REQ-012 out_y  out  WIDTH signed  gain-compensated Y at FIFO head.
REQ-013 level  out  clog2(DEPTH)+1  FIFO occupancy.
REQ-014 overflow  out  1  sticky flag: a sample was dropped.
REQ-015 ovf_clr  in  1  synchronous clear of overflow.

Function
REQ-016 Valid tracking: an STAGES-deep shift register shall carry in_valid, so that a sample presented in cycle c is tagged valid in cycle c+STAGES, when cordic_x and cordic_y hold its result.
REQ-017 Gain stage: in a tagged cycle, each of cordic_x and cordic_y shall be multiplied by K=19898 (round(0.6072529*2^15)) into a full-width signed product, and the product shall be registered together with a valid bit (one cycle).
REQ-018 Scaling: the registered product plus 2^14 shall be arithmetically shifted right by 15.
REQ-019 Saturation: the scaled result shall be saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-020 FIFO write: the saturated pair shall be written to the FIFO at the end of cycle c+STAGES+1.
REQ-021 Latency: out_valid shall be high no later than cycle c+STAGES+2 when the FIFO is empty.
REQ-022 Handshake: a pop shall occur on out_valid&&out_ready.
REQ-023 Output stability: out_x, out_y and out_valid shall be held stable while out_valid&&!out_ready.
REQ-024 Head ordering: FIFO data shall be registered/first-word-fall-through, and out_x/out_y shall show the oldest entry.
REQ-025 Simultaneous push and pop, non-empty FIFO: both shall be performed and level shall be unchanged.
REQ-026 Simultaneous push and pop, full FIFO: the push shall be accepted.
REQ-027 Simultaneous push and pop, empty FIFO: no pop shall occur; the entry shall be written and out_valid shall rise next cycle.
REQ-028 Full FIFO, push without pop: the new sample shall be discarded, overflow shall be set next cycle, and the FIFO contents shall be unchanged.
REQ-029 Overflow flag: overflow shall stay high until ovf_clr; if ovf_clr and a new drop occur in the same cycle, set shall win.
REQ-030 Pointers: read and write pointers shall wrap modulo DEPTH; level shall range 0..DEPTH.
REQ-031 Back-pressure: there is no back-pressure to the CORDIC; the block shall accept one result per clock continuously.

Reset
REQ-032 On rst_n low, the block shall asynchronously clear the valid shift register, the gain-stage valid bit, the FIFO pointers, level and overflow.
REQ-033 During reset, out_valid shall be 0 and out_x/out_y shall be 0.
REQ-034 Mid-operation reset: samples in flight shall be lost and produce no output after deassertion.
REQ-035 Deassertion: operation shall resume on the first clock edge after rst_n rises.

Structure
REQ-036 A shared package, cordic_pkg, shall hold the constants CORDIC_GAIN_INV=19898, GAIN_FRAC_BITS=15 and the default WIDTH and STAGES.
REQ-037 The FIFO shall be a sub-module, cordic_sync_fifo, parameterised on data width 2*WIDTH and DEPTH, providing level and a full flag.

Verification
REQ-038 Latency: in_valid pulse in cycle 0 with cordic_x=16468, cordic_y=0 held in cycle 16 -> out_valid rises in cycle 18 with out_x=10000, out_y=0.
REQ-039 Saturation: cordic_x=65535, cordic_y=-65536 tagged -> out_x=32767, out_y=-32768.
REQ-040 Overflow: out_ready=0 with 10 consecutive valid samples -> level=8, overflow=1, samples 9 and 10 dropped, FIFO holds samples 1..8 in order; ovf_clr pulse -> overflow=0.
REQ-041 Throughput: full FIFO, out_ready=1 and continuous input -> level stays 8, overflow stays 0, one output per clock in order.
REQ-042 Reset in flight: rst_n pulsed low in cycle 10 after an in_valid in cycle 0 -> no out_valid thereafter, level=0.
REQ-043 End to end: a bench instantiates the CORDIC with Xin=10000, Yin=0 and angles 0, 90, 180, 270 deg -> out_x/out_y within +/-3 LSB of (10000,0), (0,10000), (-10000,0), (0,-10000).
